// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared duty width, step limit and gamma curve (gamma compiled only with PWM_GAMMA_EN)
package pwm_pkg;

  localparam int         DUTY_W   = 8;
  localparam logic [7:0] STEP_TOP = 8'd254;

`ifdef PWM_GAMMA_EN
  // Squared perceptual curve; full scale is pinned so duty 255 stays continuously on.
  function automatic logic [7:0] gamma8(input logic [7:0] d);
    logic [15:0] prod;
    prod = 16'(d) * 16'(d);
    return (d == 8'd255) ? 8'd255 : prod[15:8];
  endfunction
`endif

endpackage

// File: rtl/pwm_led_driver_if.sv
// rtl/pwm_led_driver_if.sv - duty request / PWM status bundle between ramp generator and LED driver
interface pwm_led_driver_if;
  import pwm_pkg::*;

  logic [DUTY_W-1:0] duty_in;
  logic              duty_load;
  logic              pwm_out;
  logic              period_start;
  logic [DUTY_W-1:0] duty_active;

  modport master (
    output duty_in,
    output duty_load,
    input  pwm_out,
    input  period_start,
    input  duty_active
  );

  modport slave (
    input  duty_in,
    input  duty_load,
    output pwm_out,
    output period_start,
    output duty_active
  );

endinterface

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - free-running divider producing a 1-clk tick every PRESCALE clocks
module pwm_prescaler #(
  parameter int PRESCALE = 195,
  parameter int PS_W     = 8
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_cnt_q;
  logic [PS_W-1:0] ps_cnt_d;

  // With PRESCALE=1 the counter sits at 0 and tick stays high every cycle.
  assign tick = (ps_cnt_q == PS_LAST);

  // Count 0..PRESCALE-1 and wrap on the tick cycle.
  always_comb begin
    ps_cnt_d = ps_cnt_q;
    if (tick) begin
      ps_cnt_d = '0;
    end else begin
      ps_cnt_d = ps_cnt_q + PS_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_cnt_q <= '0;
    end else begin
      ps_cnt_q <= ps_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_led_driver.sv
// rtl/pwm_led_driver.sv - double-buffered 255-step LED PWM; PWM_GAMMA_EN selects the gamma-corrected duty
module pwm_led_driver
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 195,
  parameter int PS_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  pwm_led_driver_if.slave    bus
);

  logic              tick;
  logic              wrap;
  logic [DUTY_W-1:0] step_q,         step_d;
  logic [DUTY_W-1:0] shadow_q,       shadow_d;
  logic              pending_q,      pending_d;
  logic [DUTY_W-1:0] duty_active_q,  duty_active_d;
  logic              pwm_q,          pwm_d;
  logic              period_start_q, period_start_d;
  logic [DUTY_W-1:0] duty_in_f;
  logic [DUTY_W-1:0] shadow_f;

  pwm_prescaler #(
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Last step of the period: the only point where a new duty may take effect.
  assign wrap = tick && (step_q == STEP_TOP);

`ifdef PWM_GAMMA_EN
  assign duty_in_f = gamma8(bus.duty_in);
  assign shadow_f  = gamma8(shadow_q);
`else
  assign duty_in_f = bus.duty_in;
  assign shadow_f  = shadow_q;
`endif

  // Step counter, shadow capture, period-boundary apply and output decode.
  always_comb begin
    step_d         = step_q;
    shadow_d       = shadow_q;
    pending_d      = pending_q;
    duty_active_d  = duty_active_q;
    pwm_d          = (step_q < duty_active_q);
    period_start_d = wrap;

    if (tick) begin
      step_d = wrap ? '0 : step_q + DUTY_W'(1);
    end

    // Last load before the boundary wins.
    if (bus.duty_load) begin
      shadow_d  = bus.duty_in;
      pending_d = 1'b1;
    end

    // A load landing in the wrap cycle bypasses the shadow so it is not delayed a whole period.
    if (wrap) begin
      pending_d = 1'b0;
      if (bus.duty_load) begin
        duty_active_d = duty_in_f;
      end else if (pending_q) begin
        duty_active_d = shadow_f;
      end
    end
  end

  // State and output registers; reset is asynchronous so the LED drops immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q         <= '0;
      shadow_q       <= '0;
      pending_q      <= 1'b0;
      duty_active_q  <= '0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      step_q         <= step_d;
      shadow_q       <= shadow_d;
      pending_q      <= pending_d;
      duty_active_q  <= duty_active_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = period_start_q;
  assign bus.duty_active  = duty_active_q;

endmodule
